// File: rtl/pipeline_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
package pipeline_pkg;

  localparam int unsigned REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = REG_W'(0);

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    FAULT    = 2'b10
  } hz_state_t;

  // True when a producer's destination feeds a consumer source; $0 never matches.
  function automatic logic reg_hit(input logic [REG_W-1:0] dst, input logic [REG_W-1:0] src);
    return (dst != REG_ZERO) && (dst == src);
  endfunction

endpackage

// File: rtl/hazard_sequencer_if.sv
// Pipeline-side view of the hazard sequencer: register ids, stage flags and control outputs.
interface hazard_sequencer_if #(
  parameter int unsigned PERF_W = 32
);
  import pipeline_pkg::*;

  logic [REG_W-1:0] rsD, rtD, rsE, rtE;
  logic [REG_W-1:0] writeregE, writeregM, writeregW;
  logic             regwriteE, regwriteM, regwriteW;
  logic             memtoregE, memtoregM;
  logic             branchD, pcsrcD;
  logic             memaccessM, mem_ready;

  logic              mem_req;
  logic              stallF, stallD, stallE, stallM;
  logic              flushD, flushE, bubbleW;
  fwd_sel_t          forwardAE, forwardBE;
  logic              forwardAD, forwardBD;
  logic              mem_err;
  logic [PERF_W-1:0] stall_cycles;

  // Pipeline datapath side
  modport master (
    output rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
    output regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
    output branchD, pcsrcD, memaccessM, mem_ready,
    input  mem_req, stallF, stallD, stallE, stallM, flushD, flushE, bubbleW,
    input  forwardAE, forwardBE, forwardAD, forwardBD, mem_err, stall_cycles
  );

  // Hazard controller side
  modport slave (
    input  rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
    input  regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
    input  branchD, pcsrcD, memaccessM, mem_ready,
    output mem_req, stallF, stallD, stallE, stallM, flushD, flushE, bubbleW,
    output forwardAE, forwardBE, forwardAD, forwardBD, mem_err, stall_cycles
  );

endinterface

// File: rtl/forward_unit.sv
// Combinational bypass selection for the E-stage ALU operands and the D-stage branch comparator.
module forward_unit
  import pipeline_pkg::*;
(
  input  logic [REG_W-1:0] rsD,
  input  logic [REG_W-1:0] rtD,
  input  logic [REG_W-1:0] rsE,
  input  logic [REG_W-1:0] rtE,
  input  logic [REG_W-1:0] writeregM,
  input  logic [REG_W-1:0] writeregW,
  input  logic             regwriteM,
  input  logic             regwriteW,
  output fwd_sel_t         forwardAE,
  output fwd_sel_t         forwardBE,
  output logic             forwardAD,
  output logic             forwardBD
);

  // M is the younger producer, so it wins over W.
  function automatic fwd_sel_t ex_sel(input logic [REG_W-1:0] src,
                                      input logic [REG_W-1:0] wm, input logic rwm,
                                      input logic [REG_W-1:0] ww, input logic rww);
    if (rwm && reg_hit(wm, src))      return FWD_M;
    else if (rww && reg_hit(ww, src)) return FWD_W;
    else                              return FWD_RF;
  endfunction

  // Operand select for both stages
  always_comb begin
    forwardAE = ex_sel(rsE, writeregM, regwriteM, writeregW, regwriteW);
    forwardBE = ex_sel(rtE, writeregM, regwriteM, writeregW, regwriteW);
    forwardAD = regwriteM && reg_hit(writeregM, rsD);
    forwardBD = regwriteM && reg_hit(writeregM, rtD);
  end

endmodule

// File: rtl/hazard_sequencer.sv
// Central 5-stage pipeline controller: stalls, flushes, forwarding and M-stage memory sequencing.
module hazard_sequencer
  import pipeline_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned PERF_W      = 32
) (
  input logic               clk,
  input logic               rst_n,
  hazard_sequencer_if.slave bus
);

  hz_state_t         state;
  logic [CNT_W-1:0]  wait_cnt;
  logic [PERF_W-1:0] stall_cnt;

  logic lwstall, brstall, memstall;
  logic stall_f, stall_d, stall_e, stall_m;
  logic flush_d, flush_e, bubble_w, mem_req;

  forward_unit u_fwd (
    .rsD       (bus.rsD),
    .rtD       (bus.rtD),
    .rsE       (bus.rsE),
    .rtE       (bus.rtE),
    .writeregM (bus.writeregM),
    .writeregW (bus.writeregW),
    .regwriteM (bus.regwriteM),
    .regwriteW (bus.regwriteW),
    .forwardAE (bus.forwardAE),
    .forwardBE (bus.forwardBE),
    .forwardAD (bus.forwardAD),
    .forwardBD (bus.forwardBD)
  );

  // Hazard detection; a zero-wait memory never raises memstall.
  always_comb begin
    lwstall  = bus.memtoregE &&
               (reg_hit(bus.writeregE, bus.rsD) || reg_hit(bus.writeregE, bus.rtD));
    brstall  = bus.branchD &&
               ((bus.regwriteE && (reg_hit(bus.writeregE, bus.rsD) ||
                                   reg_hit(bus.writeregE, bus.rtD))) ||
                (bus.memtoregM && (reg_hit(bus.writeregM, bus.rsD) ||
                                   reg_hit(bus.writeregM, bus.rtD))));
    memstall = bus.memaccessM && !bus.mem_ready;
  end

  // Stage-register control, highest priority first: reset, fault, memory wait, data hazards.
  always_comb begin
    stall_f  = 1'b0;
    stall_d  = 1'b0;
    stall_e  = 1'b0;
    stall_m  = 1'b0;
    flush_d  = 1'b0;
    flush_e  = 1'b0;
    bubble_w = 1'b0;
    mem_req  = 1'b0;
    if (!rst_n) begin
      flush_d  = 1'b1;
      flush_e  = 1'b1;
      bubble_w = 1'b1;
    end else begin
      mem_req = bus.memaccessM && (state != FAULT);
      if (state == FAULT || memstall) begin
        stall_f  = 1'b1;
        stall_d  = 1'b1;
        stall_e  = 1'b1;
        stall_m  = 1'b1;
        bubble_w = 1'b1;
      end else if (lwstall || brstall) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end else begin
        flush_d = bus.pcsrcD;
      end
    end
  end

  // Memory-wait FSM with timeout watchdog and saturating stall counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= RUN;
      wait_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (memstall) begin
            state    <= MEM_WAIT;
            wait_cnt <= CNT_W'(1);
          end
        end
        MEM_WAIT: begin
          if (bus.mem_ready) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == CNT_W'(MEM_TIMEOUT - 1)) begin
            state <= FAULT;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        FAULT:   state <= FAULT;
        default: state <= RUN;
      endcase
      if (stall_f && (stall_cnt != '1)) stall_cnt <= stall_cnt + PERF_W'(1);
    end
  end

  // Drive the pipeline-facing outputs
  always_comb begin
    bus.stallF       = stall_f;
    bus.stallD       = stall_d;
    bus.stallE       = stall_e;
    bus.stallM       = stall_m;
    bus.flushD       = flush_d;
    bus.flushE       = flush_e;
    bus.bubbleW      = bubble_w;
    bus.mem_req      = mem_req;
    bus.mem_err      = (state == FAULT);
    bus.stall_cycles = stall_cnt;
  end

endmodule

// File: tb/tb_hazard_sequencer.sv
// Scoreboard bench for hazard_sequencer: directed vectors push expectations, a negedge monitor checks.
module tb_hazard_sequencer;
  import pipeline_pkg::*;

  typedef struct packed {
    logic [4:0] rsD, rtD, rsE, rtE, wE, wM, wW;
    logic       rwE, rwM, rwW, mtE, mtM, brD, pcD, maM, rdy;
  } vin_t;

  typedef struct {
    string       name;
    logic [8:0]  ctl;
    logic [5:0]  fwd;
    logic [31:0] sc;
  } exp_t;

  // ctl = {stallF, stallD, stallE, stallM, flushD, flushE, bubbleW, mem_req, mem_err}
  localparam logic [8:0] C_IDLE   = 9'b0000_00_000;
  localparam logic [8:0] C_RST    = 9'b0000_11_100;
  localparam logic [8:0] C_RSTF   = 9'b0000_11_101;
  localparam logic [8:0] C_HAZ    = 9'b1100_01_000;
  localparam logic [8:0] C_HAZREQ = 9'b1100_01_010;
  localparam logic [8:0] C_FLD    = 9'b0000_10_000;
  localparam logic [8:0] C_MEMST  = 9'b1111_00_110;
  localparam logic [8:0] C_MEMGO  = 9'b0000_00_010;
  localparam logic [8:0] C_FAULT  = 9'b1111_00_101;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_sequencer_if #(.PERF_W(32)) hif ();

  hazard_sequencer #(.MEM_TIMEOUT(4), .CNT_W(8), .PERF_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (hif)
  );

  exp_t        sb[$];
  int          compared   = 0;
  int          mismatched = 0;
  logic [31:0] sc_model   = '0;

  task automatic apply(input logic rst, input vin_t v);
    rst_n          = rst;
    hif.rsD        = v.rsD;
    hif.rtD        = v.rtD;
    hif.rsE        = v.rsE;
    hif.rtE        = v.rtE;
    hif.writeregE  = v.wE;
    hif.writeregM  = v.wM;
    hif.writeregW  = v.wW;
    hif.regwriteE  = v.rwE;
    hif.regwriteM  = v.rwM;
    hif.regwriteW  = v.rwW;
    hif.memtoregE  = v.mtE;
    hif.memtoregM  = v.mtM;
    hif.branchD    = v.brD;
    hif.pcsrcD     = v.pcD;
    hif.memaccessM = v.maM;
    hif.mem_ready  = v.rdy;
  endtask

  // One cycle of stimulus plus its expected response.
  task automatic step(input string name, input logic rst, input vin_t v,
                      input logic [8:0] ctl, input logic [5:0] fwd);
    exp_t e;
    @(posedge clk);
    #1;
    apply(rst, v);
    e.name = name;
    e.ctl  = ctl;
    e.fwd  = fwd;
    e.sc   = sc_model;
    sb.push_back(e);
    if (!rst)        sc_model = '0;
    else if (ctl[8]) sc_model = sc_model + 32'd1;
  endtask

  // Monitor: every cycle with a pending expectation is checked mid-cycle.
  exp_t       mon_e;
  logic [8:0] got_ctl;
  logic [5:0] got_fwd;
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e   = sb.pop_front();
      got_ctl = {hif.stallF, hif.stallD, hif.stallE, hif.stallM, hif.flushD,
                 hif.flushE, hif.bubbleW, hif.mem_req, hif.mem_err};
      got_fwd = {hif.forwardAE, hif.forwardBE, hif.forwardAD, hif.forwardBD};
      compared++;
      if (got_ctl !== mon_e.ctl) begin
        mismatched++;
        $display("FAIL %s ctl: got %b expected %b", mon_e.name, got_ctl, mon_e.ctl);
      end
      compared++;
      if (got_fwd !== mon_e.fwd) begin
        mismatched++;
        $display("FAIL %s fwd: got %b expected %b", mon_e.name, got_fwd, mon_e.fwd);
      end
      compared++;
      if (hif.stall_cycles !== mon_e.sc) begin
        mismatched++;
        $display("FAIL %s stall_cycles: got %0d expected %0d", mon_e.name, hif.stall_cycles, mon_e.sc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks pending", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    vin_t v;
    v = '0;
    apply(1'b0, v);
    repeat (2) @(posedge clk);

    step("reset_outputs", 1'b0, v, C_RST, 6'b00_00_00);
    step("idle", 1'b1, v, C_IDLE, 6'b00_00_00);

    v = '0; v.rsE = 5'd3; v.rwM = 1'b1; v.wM = 5'd3; v.rwW = 1'b1; v.wW = 5'd3;
    step("fwdAE_M_over_W", 1'b1, v, C_IDLE, 6'b10_00_00);
    v.rwM = 1'b0;
    step("fwdAE_W", 1'b1, v, C_IDLE, 6'b01_00_00);
    v = '0; v.rwM = 1'b1; v.rwW = 1'b1;
    step("fwd_reg0", 1'b1, v, C_IDLE, 6'b00_00_00);
    v = '0; v.rsE = 5'd3; v.rtE = 5'd4; v.rwM = 1'b1; v.wM = 5'd4; v.rwW = 1'b1; v.wW = 5'd3;
    step("fwd_A_W_B_M", 1'b1, v, C_IDLE, 6'b01_10_00);
    v = '0; v.rsD = 5'd6; v.rtD = 5'd9; v.rwM = 1'b1; v.wM = 5'd9;
    step("fwdBD", 1'b1, v, C_IDLE, 6'b00_00_01);

    v = '0; v.mtE = 1'b1; v.rwE = 1'b1; v.wE = 5'd5; v.rsD = 5'd5;
    step("lwstall", 1'b1, v, C_HAZ, 6'b00_00_00);
    v = '0;
    step("after_lwstall", 1'b1, v, C_IDLE, 6'b00_00_00);
    v = '0; v.mtE = 1'b1; v.rwE = 1'b1;
    step("lw_to_reg0", 1'b1, v, C_IDLE, 6'b00_00_00);

    v = '0; v.brD = 1'b1; v.pcD = 1'b1; v.rsD = 5'd7; v.rwE = 1'b1; v.wE = 5'd7;
    step("brstall_E", 1'b1, v, C_HAZ, 6'b00_00_00);
    v = '0; v.brD = 1'b1; v.pcD = 1'b1; v.rsD = 5'd7; v.rwM = 1'b1; v.wM = 5'd7;
    step("branch_taken", 1'b1, v, C_FLD, 6'b00_00_10);
    v = '0; v.brD = 1'b1; v.rtD = 5'd8; v.mtM = 1'b1; v.rwM = 1'b1; v.wM = 5'd8;
    step("brstall_loadM", 1'b1, v, C_HAZ, 6'b00_00_01);
    v = '0;
    step("idle2", 1'b1, v, C_IDLE, 6'b00_00_00);

    v = '0; v.maM = 1'b1;
    for (int i = 0; i < 3; i++) step("mem_wait", 1'b1, v, C_MEMST, 6'b00_00_00);
    v.rdy = 1'b1;
    step("mem_ready", 1'b1, v, C_MEMGO, 6'b00_00_00);
    step("mem_zero_wait", 1'b1, v, C_MEMGO, 6'b00_00_00);
    v = '0;
    step("idle3", 1'b1, v, C_IDLE, 6'b00_00_00);

    v = '0; v.maM = 1'b1; v.mtE = 1'b1; v.rwE = 1'b1; v.wE = 5'd5; v.rsD = 5'd5;
    v.brD = 1'b1; v.pcD = 1'b1;
    step("memstall_over_hazards", 1'b1, v, C_MEMST, 6'b00_00_00);
    v.rdy = 1'b1;
    step("hazard_after_mem", 1'b1, v, C_HAZREQ, 6'b00_00_00);
    v = '0;
    step("idle4", 1'b1, v, C_IDLE, 6'b00_00_00);

    v = '0; v.maM = 1'b1;
    for (int i = 0; i < 4; i++) step("timeout_wait", 1'b1, v, C_MEMST, 6'b00_00_00);
    step("fault_entered", 1'b1, v, C_FAULT, 6'b00_00_00);
    v = '0;
    step("fault_idle", 1'b1, v, C_FAULT, 6'b00_00_00);
    v.maM = 1'b1; v.rdy = 1'b1;
    step("fault_absorbing", 1'b1, v, C_FAULT, 6'b00_00_00);

    v = '0; v.maM = 1'b1;
    step("reset_in_fault", 1'b0, v, C_RSTF, 6'b00_00_00);
    v = '0;
    step("after_reset", 1'b1, v, C_IDLE, 6'b00_00_00);
    v.mtE = 1'b1; v.rwE = 1'b1; v.wE = 5'd2; v.rtD = 5'd2;
    step("lwstall_rt", 1'b1, v, C_HAZ, 6'b00_00_00);
    v = '0;
    step("count_restarted", 1'b1, v, C_IDLE, 6'b00_00_00);

    @(posedge clk);
    #1;
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/hazard_sequencer.md
Name: hazard_sequencer

Overview:
- Central pipeline controller for the 5-stage MIPS pipeline (F/D/E/M/W).
- Generates stall/flush/bubble enables for the inter-stage registers and forwarding selects for D and E.
- Sequences variable-latency data-memory accesses in M (req/ready handshake) with a timeout watchdog.
- Keeps a saturating stall-cycle performance counter.

Parameters:
- MEM_TIMEOUT, 64, consecutive M-stage wait cycles before the fault state; legal 2..2^CNT_W-1.
- CNT_W, 8, width of the wait counter.
- PERF_W, 32, width of the stall-cycle counter.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- rsD, rtD  in  5 each  D-stage source registers
- rsE, rtE  in  5 each  E-stage source registers
- writeregE, writeregM, writeregW  in  5 each  destination registers
- regwriteE, regwriteM, regwriteW  in  1 each  register-write enables
- memtoregE, memtoregM  in  1 each  load-in-stage flags
- branchD  in  1  branch in D
- pcsrcD  in  1  branch taken (resolved in D)
- memaccessM  in  1  load or store in M
- mem_ready  in  1  data memory completes the access this cycle
- mem_req  out  1  request to data memory
- stallF, stallD, stallE, stallM  out  1 each  hold the stage register
- flushD, flushE  out  1 each  clear the stage register to a bubble
- bubbleW  out  1  suppress regwrite/memtoreg entering W
- forwardAE, forwardBE  out  2 each  E operand select: 00 RF, 01 W result, 10 M aluout
- forwardAD, forwardBD  out  1 each  D comparator select of M aluout
- mem_err  out  1  sticky timeout fault
- stall_cycles  out  PERF_W  saturating count of cycles with stallF=1

Behaviour:
- Register 0 never matches for any hazard or forward check.
- Forwarding (combinational):
  - forwardAE=10 if regwriteM and writeregM==rsE.
  - Otherwise forwardAE=01 if regwriteW and writeregW==rsE.
  - Otherwise forwardAE=00. M takes priority over W.
  - forwardBE follows the same rules with rtE.
  - forwardAD = regwriteM and writeregM==rsD; forwardBD uses rtD.
- lwstall = memtoregE and writeregE in {rsD, rtD}.
- brstall = branchD and ((regwriteE and writeregE in {rsD, rtD}) or (memtoregM and writeregM in {rsD, rtD})).
- memstall = memaccessM and not mem_ready. This is combinational, so a zero-wait memory causes no stall.
- mem_req = memaccessM in RUN/MEM_WAIT; 0 in FAULT. Held high for the whole access.
- FSM states: RUN, MEM_WAIT, FAULT. Reset state is RUN.
  - RUN: if memstall, go to MEM_WAIT and set wait_cnt=1.
  - MEM_WAIT: if mem_ready, go to RUN and set wait_cnt=0. Else if wait_cnt==MEM_TIMEOUT-1, go to FAULT. Else wait_cnt+1.
  - FAULT: absorbing until reset; mem_err=1.
- Priority of stall/flush outputs:
  - FAULT: stallF/D/E/M=1, bubbleW=1, flushD=flushE=0.
  - memstall (RUN or MEM_WAIT): stallF/D/E/M=1, bubbleW=1. flushD=flushE=0; lwstall/brstall and pcsrcD are ignored that cycle.
  - Otherwise, lwstall or brstall: stallF=stallD=1, flushE=1, stallE=stallM=0, flushD=0.
  - Otherwise: flushD=pcsrcD, all else 0.
- Simultaneous lwstall and taken branch: the stall wins and the branch re-resolves next cycle.
- stall_cycles: +1 each cycle stallF=1; saturates at all-ones.
- Reset (rst_n=0 sampled at an edge):
  - Next state is RUN; wait_cnt=0, mem_err=0, stall_cycles=0.
  - While rst_n=0: all stall outputs 0, flushD=flushE=1, bubbleW=1, mem_req=0.
  - Reset mid-wait abandons the access.
- Latency: all control outputs are combinational from inputs plus state. State and counters update on the next edge.

Decomposition:
- Package pipeline_pkg:
  - fwd_sel_t enum (FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10).
  - hz_state_t enum (RUN, MEM_WAIT, FAULT).
  - REG_ZERO constant.
- Sub-module forward_unit: purely combinational, computes forwardAE/BE/AD/BD.
- The FSM, counters and stall logic stay in the top module.

Test Plan:
- add $3 in M, sub using rsE=$3 in E; also regwriteW with writeregW=$3 -> forwardAE=10. With regwriteM=0 -> forwardAE=01. With writereg=$0 -> forwardAE=00.
- lw $5 in E (memtoregE=1), add rsD=$5 -> for exactly 1 cycle stallF=stallD=flushE=1, stall_cycles +1; next cycle all 0.
- beq in D with rsD=$7 and regwriteE writeregE=$7 -> brstall one cycle; then pcsrcD=1 -> flushD=1, stallD=0.
- memaccessM=1, mem_ready low 3 cycles then high -> stallF..M=1 and bubbleW=1 for 3 cycles, mem_req=1 for 4; release on the ready cycle; stall_cycles=3.
- MEM_TIMEOUT=4, mem_ready held 0 -> FAULT entered after 4 stalled cycles; mem_err=1 and stalls stay 1. Then rst_n=0 for one edge -> mem_err=0, RUN, stall_cycles=0.
- Load-use plus taken branch in the same cycle as memstall -> only the memstall response; flushD=flushE=0.
